imem_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer that sits between the core's PC/redirect logic and the synchronous instruction ROM (imem).
- Issues word addresses to the ROM and absorbs its 1-cycle read latency.
- Buffers returned words in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Squashes stale fetches on branch/jump redirect.

---
 rtl/imem_fetch_ctrl_pkg.sv | 14 +
 rtl/imem_fetch_ctrl_fifo.sv | 58 +++++
 rtl/imem_fetch_ctrl.sv | 86 ++++++++
 tb/tb_imem_fetch_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared defaults and the prefetch FIFO entry layout for the fetch sequencer.
package imem_fetch_ctrl_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int          DEPTH_DEF    = 4;
   localparam int          ROM_AW_DEF   = 6;

   // One buffered instruction: byte PC in the upper half, word in the lower.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// Prefetch FIFO: DEPTH x 64-bit, flush beats push/pop, head is a register
// so the presented word holds its last value once the FIFO drains.
module fetch_fifo
   import imem_fetch_ctrl_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clka,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [63:0]              din,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic [63:0]              head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [63:0]   mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
   logic          do_push, do_pop;

   assign do_push = push & ~flush;
   assign do_pop  = pop & ~flush & (count != '0);
   assign rd_nxt  = rd_ptr + 1'b1;

   // Storage array, written only on an accepted push.
   always_ff @(posedge clka) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers, occupancy and the registered head word.
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_nxt;
         count <= count + CW'(do_push) - CW'(do_pop);
         // Next head is either the entry behind the popped one, or the
         // incoming word when it lands in an empty (or emptying) FIFO.
         if (do_pop && count > CW'(1))
            head <= mem[rd_nxt];
         else if (do_push && (count == '0 || (do_pop && count == CW'(1))))
            head <= din;
      end
   end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: issues ROM reads under a credit limit,
// tags each read with its PC, and buffers responses for decode.
module imem_fetch_ctrl
   import imem_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = DEPTH_DEF,
   parameter int          ROM_AW   = ROM_AW_DEF
) (
   input  logic              clka,
   input  logic              rst_n,
   input  logic              fetch_en,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              rom_en,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_rdata,
   output logic              inst_valid,
   output logic [31:0]       inst,
   output logic [31:0]       inst_pc,
   input  logic              inst_ready
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   pc_q, req_pc_q, redir_base;
   logic          inflight_q, squash, push, pop, issue;
   logic [CW-1:0] count;
   logic [CW:0]   avail;
   logic [63:0]   head_bits;
   fetch_entry_t  push_ent, head_ent;
   logic          unused_pc_lsb;

   assign redir_base    = {redirect_pc[31:2], 2'b00};
   assign unused_pc_lsb = &{1'b0, redirect_pc[1:0]};

   // Credit check: entries held plus the one landing, minus the one leaving,
   // must leave a free slot for a read issued now.
   always_comb begin
      pop      = inst_valid & inst_ready;
      avail    = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
      issue    = redirect_valid | (fetch_en & (avail < (CW+1)'(DEPTH)));
      // A redirect kills whatever response lands in the same cycle.
      squash   = redirect_valid;
      push     = inflight_q & ~squash;
      rom_addr = redirect_valid ? redirect_pc[ROM_AW+1:2] : pc_q[ROM_AW+1:2];
      push_ent = '{pc: req_pc_q, inst: rom_rdata};
      head_ent = fetch_entry_t'(head_bits);
   end

   // Gate the ROM strobe while reset is held so nothing issues pre-release.
   assign rom_en     = issue & rst_n;
   assign inst_valid = (count != '0);
   assign inst       = head_ent.inst;
   assign inst_pc    = head_ent.pc;

   // Fetch PC, in-flight request PC and the in-flight flag.
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (redirect_valid) begin
            req_pc_q <= redir_base;
            pc_q     <= redir_base + 32'd4;
         end else if (issue) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
         end
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clka  (clka),
      .rst_n (rst_n),
      .push  (push),
      .din   (push_ent),
      .pop   (pop),
      .flush (redirect_valid),
      .count (count),
      .head  (head_bits)
   );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: reset-relative vector table, directed corner
// sequences, then random traffic against a stream-level scoreboard.
module tb_imem_fetch_ctrl;

   localparam int DEPTH = 4;

   logic        clka = 1'b0;
   logic        rst_n = 1'b1;
   logic        fetch_en = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        rom_en;
   logic [5:0]  rom_addr;
   logic [31:0] rom_rdata = '0;
   logic        inst_valid;
   logic [31:0] inst, inst_pc;
   logic        inst_ready = 1'b0;

   imem_fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(DEPTH), .ROM_AW(6)) dut (
      .clka           (clka),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .rom_en         (rom_en),
      .rom_addr       (rom_addr),
      .rom_rdata      (rom_rdata),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
   );

   always #5 clka = ~clka;

   // Synchronous ROM model, one-cycle read latency.
   logic [31:0] rom [64];
   always @(posedge clka) if (rom_en) rom_rdata <= rom[rom_addr];

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word(input logic [31:0] pc);
      return 32'hA000_0000 + {26'd0, pc[7:2]};
   endfunction

   // Stream-level reference: program order after each redirect, and an
   // occupancy count of words that reached the buffer but not decode.
   logic [31:0] m_pc, m_issue, m_hold_inst, m_hold_pc;
   int          m_occ, deliveries;
   bit          m_prev_issue, m_hold, m_after_redir;

   task automatic model_reset();
      m_pc = 32'h0; m_issue = 32'h0; m_occ = 0;
      m_prev_issue = 0; m_hold = 0; m_after_redir = 0;
   endtask

   task automatic model_step();
      bit pop;
      pop = inst_valid & inst_ready;
      if (m_after_redir) chk("valid_after_redirect", inst_valid, 0);
      chk("valid_vs_occupancy", inst_valid, m_occ != 0);
      if (m_hold) begin
         chk("hold_valid", inst_valid, 1);
         chk("hold_inst", inst, m_hold_inst);
         chk("hold_pc", inst_pc, m_hold_pc);
      end
      if (redirect_valid) begin
         chk("redirect_issue", rom_en, 1);
         chk("redirect_addr", rom_addr, redirect_pc[7:2]);
         m_pc = {redirect_pc[31:2], 2'b00};
         m_issue = m_pc + 32'd4;
         m_occ = 0;
         m_prev_issue = 1;
      end else begin
         if (pop) begin
            chk("deliver_pc", inst_pc, m_pc);
            chk("deliver_inst", inst, word(m_pc));
            m_pc += 32'd4;
            deliveries++;
         end
         if (rom_en) begin
            chk("issue_addr", rom_addr, m_issue[7:2]);
            m_issue += 32'd4;
         end
         if (!fetch_en) chk("no_issue_disabled", rom_en, 0);
         m_occ = m_occ + int'(m_prev_issue) - int'(pop);
         chk("fifo_bound", m_occ <= DEPTH, 1);
         m_prev_issue = rom_en;
      end
      m_hold = inst_valid & ~inst_ready & ~redirect_valid;
      m_hold_inst = inst;
      m_hold_pc = inst_pc;
      m_after_redir = redirect_valid;
   endtask

   task automatic cycle(input bit en, input bit rdy, input bit rv, input logic [31:0] rpc);
      @(negedge clka);
      fetch_en = en; inst_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
      #1;
      model_step();
   endtask

   task automatic do_reset();
      @(negedge clka);
      rst_n = 1'b0; fetch_en = 0; inst_ready = 0; redirect_valid = 0;
      #1;
      chk("reset_valid", inst_valid, 0);
      chk("reset_inst", inst, 0);
      chk("reset_pc", inst_pc, 0);
      chk("reset_rom_en", rom_en, 0);
      @(negedge clka);
      @(negedge clka);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic wait_deliver(output logic [31:0] pc, output logic [31:0] ins);
      pc = '1; ins = '1;
      for (int i = 0; i < 20; i++) begin
         cycle(1, 1, 0, 0);
         if (inst_valid) begin
            pc = inst_pc; ins = inst;
            return;
         end
      end
   endtask

   typedef struct {
      bit          en;
      bit          rdy;
      bit          e_en;
      logic [5:0]  e_addr;
      bit          e_v;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pc, ins, exp_pc;
      int d0;
      for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 + i;
      model_reset();
      deliveries = 0;

      // Stream from reset, then a 4-cycle decode stall and resume.
      vecs[0]  = '{1, 1, 1, 6'd0, 0, 32'h00};
      vecs[1]  = '{1, 1, 1, 6'd1, 0, 32'h00};
      vecs[2]  = '{1, 1, 1, 6'd2, 1, 32'h00};
      vecs[3]  = '{1, 1, 1, 6'd3, 1, 32'h04};
      vecs[4]  = '{1, 0, 1, 6'd4, 1, 32'h08};
      vecs[5]  = '{1, 0, 1, 6'd5, 1, 32'h08};
      vecs[6]  = '{1, 0, 0, 6'd6, 1, 32'h08};
      vecs[7]  = '{1, 0, 0, 6'd6, 1, 32'h08};
      vecs[8]  = '{1, 1, 1, 6'd6, 1, 32'h08};
      vecs[9]  = '{1, 1, 1, 6'd7, 1, 32'h0C};
      vecs[10] = '{1, 1, 1, 6'd8, 1, 32'h10};
      vecs[11] = '{1, 1, 1, 6'd9, 1, 32'h14};

      do_reset();
      for (int i = 0; i < 12; i++) begin
         cycle(vecs[i].en, vecs[i].rdy, 0, 0);
         chk($sformatf("vec%0d_rom_en", i), rom_en, vecs[i].e_en);
         chk($sformatf("vec%0d_rom_addr", i), rom_addr, vecs[i].e_addr);
         chk($sformatf("vec%0d_valid", i), inst_valid, vecs[i].e_v);
         if (vecs[i].e_v) begin
            chk($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_inst", i), inst, word(vecs[i].e_pc));
         end
      end

      // Redirect with 3 buffered entries and one read in flight.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
      cycle(1, 0, 1, 32'h0000_0043);
      chk("redir43_rom_en", rom_en, 1);
      chk("redir43_addr", rom_addr, 6'h10);
      cycle(1, 1, 0, 0);
      chk("redir43_valid_low", inst_valid, 0);
      wait_deliver(pc, ins);
      chk("redir43_first_pc", pc, 32'h40);
      chk("redir43_first_inst", ins, 32'hA000_0010);
      wait_deliver(pc, ins);
      chk("redir43_second_pc", pc, 32'h44);

      // Back-to-back redirects: only the second target is ever delivered.
      cycle(1, 1, 1, 32'h20);
      cycle(1, 1, 1, 32'h80);
      wait_deliver(pc, ins);
      chk("dbl_redir_pc", pc, 32'h80);
      chk("dbl_redir_inst", ins, 32'hA000_0020);

      // fetch_en low mid-stream: issue stops, in-flight word still lands.
      for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
      cycle(0, 1, 0, 0);
      chk("disable_rom_en", rom_en, 0);
      cycle(0, 1, 0, 0);
      chk("disable_inflight_lands", inst_valid, 1);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
      chk("disable_drained", inst_valid, 0);
      exp_pc = m_pc;
      wait_deliver(pc, ins);
      chk("reenable_seq_pc", pc, exp_pc);

      // Word-address wrap at the top of the ROM.
      cycle(1, 1, 1, 32'h0000_00FC);
      wait_deliver(pc, ins);
      chk("wrap_pc_fc", pc, 32'hFC);
      chk("wrap_inst_63", ins, 32'hA000_003F);
      wait_deliver(pc, ins);
      chk("wrap_pc_100", pc, 32'h100);
      chk("wrap_inst_0", ins, 32'hA000_0000);

      // Asynchronous reset in the middle of a stream.
      cycle(1, 1, 0, 0);
      chk("pre_reset_valid", inst_valid, 1);
      #2;
      rst_n = 1'b0; fetch_en = 0; inst_ready = 0;
      #1;
      chk("async_reset_valid", inst_valid, 0);
      chk("async_reset_rom_en", rom_en, 0);
      model_reset();
      @(negedge clka);
      @(negedge clka);
      rst_n = 1'b1;
      cycle(1, 1, 0, 0);
      chk("post_reset_rom_en", rom_en, 1);
      chk("post_reset_addr", rom_addr, 0);

      // Random traffic against the scoreboard.
      d0 = deliveries;
      for (int i = 0; i < 600; i++)
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6,
               $urandom_range(0, 19) == 0, $urandom);
      chk("random_progress", (deliveries - d0) > 50, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
